// File: rtl/led_port_scan_if.sv
// led_port_scan_if: port bundle between per-port MAC status and the shared LED scheduler
// Ports: LINK/ACT per-port link level and activity strobe, HOLD freeze request (MAC side);
//        LINK_O/ACT_O indicator drive, SEL scheduled port, ID_PHASE preamble flag (LED side).
interface led_port_scan_if #(
    parameter int NPorts  = 4,
    parameter int IdxBits = 2
);
    logic [NPorts-1:0]  LINK;
    logic [NPorts-1:0]  ACT;
    logic               HOLD;
    logic               LINK_O;
    logic               ACT_O;
    logic [IdxBits-1:0] SEL;
    logic               ID_PHASE;
    modport master (output LINK, ACT, HOLD, input LINK_O, ACT_O, SEL, ID_PHASE);
    modport slave  (input LINK, ACT, HOLD, output LINK_O, ACT_O, SEL, ID_PHASE);
endinterface

// File: rtl/led_port_scan.sv
// led_port_scan: round-robin sharing of one LINK/ACT LED among NPorts ports with port-ID blink preamble
// Ports: CLK clock; RST synchronous active-high reset;
//        bus.LINK/ACT/HOLD in, bus.LINK_O/ACT_O/SEL/ID_PHASE registered out.
module led_port_scan #(
    parameter int NPorts    = 4,
    parameter int IdxBits   = 2,
    parameter int PulseBits = 23,
    parameter int DwellBits = 27,
    parameter bit SkipDown  = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    led_port_scan_if.slave bus
);
    typedef enum logic [1:0] {SCAN, ID, GAP, SHOW} state_t;
    state_t               state_q, state_d;
    logic [IdxBits-1:0]   sel_q, sel_d;
    logic [NPorts-1:0]    pend_q, pend_d;
    logic [PulseBits:0]   phase_q, phase_d;
    logic [IdxBits:0]     pulse_q, pulse_d;
    logic [DwellBits-1:0] dwell_q, dwell_d;
    logic                 first_q, first_d;
    logic                 link_o_q, link_o_d;
    logic                 act_o_q, act_o_d;
    logic                 id_phase_q, id_phase_d;
    logic [NPorts-1:0]    elig;
    logic [IdxBits-1:0]   idx, cand;
    logic                 found;

    assign elig = SkipDown ? (bus.LINK | pend_q) : '1;

    // Search SEL+1, SEL+2, ... wrapping to SEL itself last
    always_comb begin
        found = 1'b0;
        cand  = sel_q;
        idx   = sel_q;
        for (int k = 1; k <= NPorts; k++) begin
            idx = IdxBits'((int'(sel_q) + k) % NPorts);
            if (!found && elig[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        phase_d    = phase_q + 1'b1;
        pulse_d    = pulse_q;
        dwell_d    = dwell_q;
        link_o_d   = 1'b0;
        act_o_d    = 1'b0;
        id_phase_d = 1'b0;
        case (state_q)
            SCAN: begin
                state_d = found ? ID : SCAN;
                sel_d   = found ? cand : sel_q;
            end
            ID: begin
                // phase MSB low = LED on half of the pulse
                link_o_d   = ~phase_q[PulseBits];
                id_phase_d = 1'b1;
                if (&phase_q) begin
                    pulse_d = pulse_q + 1'b1;
                    state_d = (pulse_q == {1'b0, sel_q}) ? GAP : ID;
                end
            end
            GAP: begin
                id_phase_d = 1'b1;
                state_d    = (&phase_q) ? SHOW : GAP;
            end
            default: begin
                link_o_d = bus.LINK[sel_q];
                act_o_d  = bus.ACT[sel_q] | (first_q & pend_q[sel_q]);
                if (!bus.HOLD) begin
                    dwell_d = dwell_q + 1'b1;
                    state_d = (&dwell_q) ? SCAN : SHOW;
                end
            end
        endcase
        if (state_d != state_q) begin
            phase_d = '0;
            pulse_d = '0;
            dwell_d = '0;
        end
        first_d = (state_d == SHOW) && (state_q != SHOW);
    end

    // Activity on the displayed port passes straight through; elsewhere it is latched for replay
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NPorts; i++)
            pend_d[i] = (pend_q[i] & ~(first_q && state_q == SHOW && sel_q == IdxBits'(i)))
                      | (bus.ACT[i] & ~(state_q == SHOW && sel_q == IdxBits'(i)));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= SCAN;
            sel_q      <= IdxBits'(NPorts - 1);
            pend_q     <= '0;
            phase_q    <= '0;
            pulse_q    <= '0;
            dwell_q    <= '0;
            first_q    <= 1'b0;
            link_o_q   <= 1'b0;
            act_o_q    <= 1'b0;
            id_phase_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            pend_q     <= pend_d;
            phase_q    <= phase_d;
            pulse_q    <= pulse_d;
            dwell_q    <= dwell_d;
            first_q    <= first_d;
            link_o_q   <= link_o_d;
            act_o_q    <= act_o_d;
            id_phase_q <= id_phase_d;
        end
    end

    assign bus.LINK_O   = link_o_q;
    assign bus.ACT_O    = act_o_q;
    assign bus.SEL      = sel_q;
    assign bus.ID_PHASE = id_phase_q;
endmodule

// File: tb/tb_led_port_scan.sv
// tb_led_port_scan: directed self-checking bench for led_port_scan (NPorts=4, PulseBits=2, DwellBits=4)
module tb_led_port_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic       lo [0:255];
    logic       ao [0:255];
    logic       ip [0:255];
    logic [1:0] sl [0:255];

    led_port_scan_if #(.NPorts(4), .IdxBits(2)) bus ();

    led_port_scan #(
        .NPorts(4), .IdxBits(2), .PulseBits(2), .DwellBits(4), .SkipDown(1'b1)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // sample k holds the outputs right after the k-th edge following reset release
    task automatic step(input int k);
        @(posedge clk);
        @(negedge clk);
        lo[k] = bus.LINK_O;
        ao[k] = bus.ACT_O;
        ip[k] = bus.ID_PHASE;
        sl[k] = bus.SEL;
    endtask

    task automatic do_reset(input logic [3:0] link);
        rst      = 1'b1;
        bus.LINK = link;
        bus.ACT  = 4'b0;
        bus.HOLD = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        bus.LINK = 4'b1111;
        bus.ACT  = 4'b1111;
        bus.HOLD = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.SEL !== 2'd3) begin errors++; $display("FAIL reset_sel got=%0d exp=3", bus.SEL); end
        checks++; if (bus.LINK_O !== 1'b0) begin errors++; $display("FAIL reset_link_o got=%b exp=0", bus.LINK_O); end
        checks++; if (bus.ACT_O !== 1'b0) begin errors++; $display("FAIL reset_act_o got=%b exp=0", bus.ACT_O); end
        checks++; if (bus.ID_PHASE !== 1'b0) begin errors++; $display("FAIL reset_id_phase got=%b exp=0", bus.ID_PHASE); end
    endtask

    task automatic test_rotation;
        int pos [8] = '{33, 34, 74, 75, 123, 124, 180, 181};
        int exs [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
        logic [33:0] got_v, exp_v;
        int cnt;
        do_reset(4'b1111);
        for (int k = 1; k <= 190; k++) step(k);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sl[pos[i]] !== 2'(exs[i])) begin
                errors++; $display("FAIL rot_sel[%0d] got=%0d exp=%0d", pos[i], sl[pos[i]], exs[i]);
            end
        end
        for (int k = 1; k <= 34; k++) begin
            got_v[k-1] = lo[k];
            exp_v[k-1] = (k >= 2 && k <= 5) || (k >= 18 && k <= 33);
        end
        checks++; if (got_v !== exp_v) begin errors++; $display("FAIL rot_port0_wave got=%b exp=%b", got_v, exp_v); end
        for (int p = 0; p < 4; p++) begin
            cnt = 0;
            for (int k = 1; k <= 180; k++) if (sl[k] == 2'(p) && ip[k]) cnt++;
            checks++;
            if (cnt != 8 * (p + 1) + 8) begin errors++; $display("FAIL rot_idphase_len[%0d] got=%0d exp=%0d", p, cnt, 8 * (p + 1) + 8); end
        end
        cnt = 0;
        for (int k = 1; k <= 180; k++) if (sl[k] == 2'd3 && ip[k] && lo[k]) cnt++;
        checks++; if (cnt != 16) begin errors++; $display("FAIL rot_port3_id_high got=%0d exp=16", cnt); end
    endtask

    task automatic test_skip;
        int cnt;
        do_reset(4'b0100);
        for (int k = 1; k <= 120; k++) step(k);
        cnt = 0;
        for (int k = 1; k <= 120; k++) if (sl[k] !== 2'd2) cnt++;
        checks++; if (cnt != 0) begin errors++; $display("FAIL skip_sel_not2 got=%0d exp=0", cnt); end
        checks++; if (ip[50] !== 1'b0) begin errors++; $display("FAIL skip_scan_gap got=%b exp=0", ip[50]); end
        checks++; if (ip[51] !== 1'b1) begin errors++; $display("FAIL skip_revisit got=%b exp=1", ip[51]); end
        cnt = 0;
        for (int k = 2; k <= 25; k++) if (lo[k]) cnt++;
        checks++; if (cnt != 12) begin errors++; $display("FAIL skip_id_pulses got=%0d exp=12", cnt); end
        do_reset(4'b0000);
        for (int k = 1; k <= 20; k++) step(k);
        cnt = 0;
        for (int k = 1; k <= 20; k++) if (lo[k] !== 1'b0 || ao[k] !== 1'b0 || ip[k] !== 1'b0 || sl[k] !== 2'd3) cnt++;
        checks++; if (cnt != 0) begin errors++; $display("FAIL skip_idle_samples got=%0d exp=0", cnt); end
    endtask

    task automatic test_pending;
        int cnt, bad;
        do_reset(4'b0001);
        for (int k = 1; k <= 150; k++) begin
            step(k);
            if (k == 20) bus.ACT = 4'b0010;
            if (k == 21) bus.ACT = 4'b0000;
        end
        checks++; if (sl[34] !== 2'd1) begin errors++; $display("FAIL pend_visit got=%0d exp=1", sl[34]); end
        checks++; if (ao[59] !== 1'b1) begin errors++; $display("FAIL pend_replay got=%b exp=1", ao[59]); end
        cnt = 0;
        for (int k = 1; k <= 150; k++) if (ao[k]) cnt++;
        checks++; if (cnt != 1) begin errors++; $display("FAIL pend_replay_count got=%0d exp=1", cnt); end
        bad = 0;
        for (int k = 75; k <= 150; k++) if (sl[k] !== 2'd0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL pend_cleared_revisits got=%0d exp=0", bad); end
    endtask

    task automatic test_act_passthrough;
        int cnt;
        do_reset(4'b0100);
        for (int k = 1; k <= 110; k++) begin
            step(k);
            if (k == 36 || k == 39 || k == 42) bus.ACT = 4'b0100;
            if (k == 37 || k == 40 || k == 43) bus.ACT = 4'b0000;
        end
        checks++; if ({ao[37], ao[40], ao[43]} !== 3'b111) begin errors++; $display("FAIL pass_pulses got=%b exp=111", {ao[37], ao[40], ao[43]}); end
        cnt = 0;
        for (int k = 1; k <= 110; k++) if (ao[k]) cnt++;
        checks++; if (cnt != 3) begin errors++; $display("FAIL pass_count got=%0d exp=3", cnt); end
        checks++; if (ao[83] !== 1'b0) begin errors++; $display("FAIL pass_no_replay got=%b exp=0", ao[83]); end
    endtask

    task automatic test_hold;
        int cnt;
        do_reset(4'b0001);
        for (int k = 1; k <= 60; k++) begin
            step(k);
            if (k == 20) bus.HOLD = 1'b1;
            if (k == 40) bus.HOLD = 1'b0;
        end
        cnt = 0;
        for (int k = 18; k <= 53; k++) if (lo[k] && !ip[k]) cnt++;
        checks++; if (cnt != 36) begin errors++; $display("FAIL hold_show_len got=%0d exp=36", cnt); end
        checks++; if (lo[54] !== 1'b0) begin errors++; $display("FAIL hold_scan got=%b exp=0", lo[54]); end
        checks++; if (ip[53] !== 1'b0) begin errors++; $display("FAIL hold_show_end got=%b exp=0", ip[53]); end
        checks++; if (ip[55] !== 1'b1) begin errors++; $display("FAIL hold_next_id got=%b exp=1", ip[55]); end
        do_reset(4'b0001);
        bus.HOLD = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(k);
            if (k == 12) bus.HOLD = 1'b0;
        end
        checks++; if (ip[17] !== 1'b1) begin errors++; $display("FAIL hold_id_gap_end got=%b exp=1", ip[17]); end
        checks++; if (ip[18] !== 1'b0) begin errors++; $display("FAIL hold_id_show_start got=%b exp=0", ip[18]); end
        checks++; if (lo[18] !== 1'b1) begin errors++; $display("FAIL hold_id_show_link got=%b exp=1", lo[18]); end
    endtask

    task automatic test_reset_mid;
        int bad;
        do_reset(4'b1111);
        for (int k = 1; k <= 140; k++) begin
            step(k);
            if (k == 76) bus.ACT = 4'b1010;
            if (k == 77) bus.ACT = 4'b0000;
            if (k == 78) begin rst = 1'b1; bus.LINK = 4'b0001; end
            if (k == 79) rst = 1'b0;
        end
        checks++; if (sl[78] !== 2'd2 || lo[78] !== 1'b1) begin errors++; $display("FAIL rmid_pre sel=%0d link_o=%b exp sel=2 link_o=1", sl[78], lo[78]); end
        checks++; if (sl[79] !== 2'd3) begin errors++; $display("FAIL rmid_sel got=%0d exp=3", sl[79]); end
        checks++; if (lo[79] !== 1'b0 || ip[79] !== 1'b0 || ao[79] !== 1'b0) begin errors++; $display("FAIL rmid_outs got=%b%b%b exp=000", lo[79], ip[79], ao[79]); end
        checks++; if (sl[80] !== 2'd0) begin errors++; $display("FAIL rmid_next got=%0d exp=0", sl[80]); end
        bad = 0;
        for (int k = 80; k <= 140; k++) if (sl[k] !== 2'd0 || ao[k] !== 1'b0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rmid_pend_discarded got=%0d exp=0", bad); end
    endtask

    initial begin
        bus.LINK = 4'b0;
        bus.ACT  = 4'b0;
        bus.HOLD = 1'b0;
        test_reset;
        test_rotation;
        test_skip;
        test_pending;
        test_act_passthrough;
        test_hold;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_port_scan.md
# led_port_scan

Round-robin LED scheduler that shares one LINK/ACT LED indicator among several network ports. For each port in turn it emits a port-ID blink preamble, then forwards that port's LINK level and ACT strobes to the downstream LINK/ACT indicator for a fixed dwell time. ACT events on ports not currently displayed are latched and replayed, so no port's activity is lost. It sits between the per-port MAC status signals and the board's single LED indicator instance.

## Interface

- NPorts, 4, number of ports sharing the LED (2..16)
- IdxBits, 2, width of port index; must equal ceil(log2(NPorts))
- PulseBits, 23, ID pulse half-period is 2^PulseBits cycles
- DwellBits, 27, SHOW duration is 2^DwellBits cycles
- SkipDown, 1, 1: skip ports with LINK=0 and no pending ACT; 0: visit every port

Ports:

- CLK  in  1  single clock
- RST  in  1  synchronous reset, active-high
- LINK  in  NPorts  per-port link-up level
- ACT  in  NPorts  per-port activity strobe (any width pulse)
- HOLD  in  1  freeze on current port while in SHOW
- LINK_O  out  1  to indicator LINK input, registered
- ACT_O  out  1  to indicator ACT input, registered
- SEL  out  IdxBits  port currently scheduled, registered
- ID_PHASE  out  1  high during ID and GAP states

## Operation

- States: SCAN, ID, GAP, SHOW.
- Reset: state=SCAN, SEL=NPorts-1, so the first pick is port 0. PENDING=0, all counters 0. LINK_O=0, ACT_O=0, ID_PHASE=0.
- Eligibility: port i is eligible iff SkipDown=0, or LINK[i]=1, or PENDING[i]=1.
- SCAN:
  - Choose the first eligible port in the order SEL+1, SEL+2, ... (mod NPorts), wrapping back to SEL itself last.
  - If one is found: SEL<=that port and go to ID.
  - If none is found: stay in SCAN, hold SEL, and re-evaluate every cycle.
  - LINK_O=0, ACT_O=0, ID_PHASE=0.
- ID:
  - Emit SEL+1 pulses. Each pulse is LINK_O=1 for 2^PulseBits cycles, then LINK_O=0 for 2^PulseBits cycles.
  - ACT_O=0, ID_PHASE=1. A pulse counter counts completed pulses.
  - After pulse SEL+1 completes, go to GAP.
- GAP:
  - LINK_O=0, ACT_O=0, ID_PHASE=1 for 2^(PulseBits+1) cycles, then go to SHOW.
- SHOW:
  - LINK_O<=LINK[SEL] and ACT_O<=ACT[SEL] every cycle. ID_PHASE=0.
  - On the first SHOW cycle, ACT_O<=1 if PENDING[SEL]=1, and PENDING[SEL] clears.
  - The dwell counter increments each cycle unless HOLD=1.
  - When the dwell counter wraps to 0 (after 2^DwellBits counted cycles), go to SCAN.
- PENDING update:
  - PENDING[i] <= (PENDING[i] & ~clr_i) | (ACT[i] & ~(state==SHOW & SEL==i)).
  - clr_i is the first-SHOW-cycle clear.
  - ACT on the displayed port during SHOW passes straight through and is never latched.
  - ACT during ID/GAP of the same port is latched and replayed at SHOW entry.
- LINK falling during SHOW: keep displaying (LINK_O goes 0) until dwell ends. No early exit.
- HOLD has effect only in SHOW. In SCAN, ID and GAP it is ignored.
- RST asserted in any state: all registers return to reset values on the next edge; PENDING is discarded.
- Counters:
  - Phase counter is PulseBits+1 bits; its MSB inverted gives the pulse level.
  - Pulse counter is IdxBits+1 bits.
  - Dwell counter is DwellBits bits.
  - All counters are cleared on every state entry.

## Timing

- All outputs are registered: one cycle latency from state/input to pin.
- SCAN→ID decision: 1 cycle when an eligible port exists.
- ID length = (SEL+1)·2^(PulseBits+1) cycles.
- GAP length = 2^(PulseBits+1) cycles.
- SHOW length = 2^DwellBits cycles plus the number of HOLD cycles.
- Full rotation with all ports eligible = Σ over ports of (1 + ID + GAP + SHOW).
- ACT to ACT_O latency in SHOW: 1 cycle. A pending replay is a single-cycle ACT_O pulse at the SHOW entry edge.
- Simultaneous ACT on several non-displayed ports: all latch independently in the same cycle.

## Test plan

Bench parameters: NPorts=4, PulseBits=2, DwellBits=4.

- **Reset, all LINK=1, no ACT:** SEL goes 0,1,2,3,0. Port 0 shows 4 high/4 low on LINK_O, 8 low (GAP), then 16 cycles of LINK_O=1. Port 3 shows 4 pulses (32 cycles) before its GAP.
- **LINK=4'b0100, SkipDown=1:** only SEL=2 is visited, repeatedly. LINK=0: SCAN holds, LINK_O=ACT_O=0, SEL stays 3.
- **1-cycle ACT[1] while SEL=0 in SHOW:** PENDING[1] sets. Port 1 is visited even with LINK[1]=0, and ACT_O pulses exactly once on the first SHOW cycle of port 1. PENDING[1] then reads 0.
- **ACT[2] pulsed 3 times during SHOW of port 2:** ACT_O shows 3 pulses, each 1 cycle later. PENDING[2] stays 0, so there is no replay on the next visit.
- **HOLD=1 for 20 cycles mid-SHOW:** SHOW lasts 36 cycles. HOLD asserted during ID has no effect (ID still 8·(SEL+1) cycles).
- **RST pulsed mid-ID of port 2 with PENDING=4'b1010:** next cycle state=SCAN, SEL=3, PENDING=0, LINK_O=0. The next visit is port 0.
